// File: rtl/arbiter_rr_n_if.sv
// Request/grant bundle between the request sources (master) and arbiter_rr_n (slave).
interface arbiter_rr_n_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0] req;
  logic            rr_mode;
  logic            finish;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] sel;
  logic [IDW-1:0]  gnt_id;
  logic            busy;
  logic            timeout;

  modport master (
    output req, rr_mode, finish,
    input  gnt, sel, gnt_id, busy, timeout
  );

  modport slave (
    input  req, rr_mode, finish,
    output gnt, sel, gnt_id, busy, timeout
  );
endinterface

// File: rtl/arbiter_rr_n.sv
// N-way fixed-priority / round-robin arbiter that holds a grant until finish.
// Optional grant watchdog is built only when ARB_TIMEOUT_EN is defined.
module arbiter_rr_n #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  arbiter_rr_n_if.slave bus
);

  if (NREQ < 2 || NREQ > 16 || IDW != $clog2(NREQ) || TMO_CYC < 2) begin : g_cfg_err
    $error("arbiter_rr_n: illegal parameter combination");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] gnt_q, sel_q, gnt_nx;
  logic [IDW-1:0]  id_q, id_nx, ptr_q, ptr_nx, win;
  logic            busy_q, busy_nx, tmo_q, tmo_nx;
  logic            any_req, tmo_hit;

  assign any_req = |bus.req;

  // Winner: first set request scanning upward from base (0 in fixed mode), wrapping at NREQ.
  always_comb begin : p_win
    int unsigned base;
    int unsigned j;
    logic        found;
    win   = '0;
    found = 1'b0;
    base  = bus.rr_mode ? int'(ptr_q) : 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = base + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && bus.req[j]) begin
        win   = IDW'(j);
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TMO_CYC);
  logic [TCW-1:0] tmo_cnt;

  // Cycles spent in GRANT; sits at zero in IDLE so every grant starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_cnt <= '0;
    else if (state == GRANT) tmo_cnt <= tmo_cnt + TCW'(1);
    else                     tmo_cnt <= '0;
  end

  assign tmo_hit = (state == GRANT) && !bus.finish && (tmo_cnt == TCW'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      gnt_q  <= '0;
      sel_q  <= '0;
      id_q   <= '0;
      ptr_q  <= '0;
      busy_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      gnt_q  <= gnt_nx;
      sel_q  <= gnt_nx;
      id_q   <= id_nx;
      ptr_q  <= ptr_nx;
      busy_q <= busy_nx;
      tmo_q  <= tmo_nx;
    end
  end

  always_comb begin : p_next_state
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = GRANT;
      GRANT:   if (bus.finish || tmo_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the output registers; finish wins over the watchdog.
  always_comb begin : p_outputs
    gnt_nx  = gnt_q;
    id_nx   = id_q;
    ptr_nx  = ptr_q;
    busy_nx = busy_q;
    tmo_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nx  = NREQ'(1) << win;
          id_nx   = win;
          busy_nx = 1'b1;
          ptr_nx  = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        end
      end
      GRANT: begin
        if (bus.finish) begin
          gnt_nx  = '0;
          busy_nx = 1'b0;
        end else if (tmo_hit) begin
          gnt_nx  = '0;
          busy_nx = 1'b0;
          tmo_nx  = 1'b1;
        end
      end
      default: begin
        gnt_nx  = '0;
        busy_nx = 1'b0;
      end
    endcase
  end

  assign bus.gnt    = gnt_q;
  assign bus.sel    = sel_q;
  assign bus.gnt_id = id_q;
  assign bus.busy   = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = tmo_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule
